// File: rtl/ysyx_25040129_pkg.sv
// Shared AXI response/burst codes, FSM state type and address legality helper
// for the ysyx_25040129 burst SRAM.
package ysyx_25040129_pkg;

   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespSlverr = 2'b10;

   localparam logic [1:0] BurstFixed = 2'b00;
   localparam logic [1:0] BurstIncr  = 2'b01;
   localparam logic [1:0] BurstWrap  = 2'b10;

   typedef enum logic [2:0] {
      StIdle,
      StRLat,
      StRData,
      StWData,
      StWResp
   } sram_state_e;

   // Word-aligned and inside [base, base + 4*2^dig), computed modulo 2^32.
   function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] base,
                                          input int unsigned dig);
      logic [31:0] off;
      off = addr - base;
      return (addr[1:0] == 2'b00) && ((off >> (dig + 2)) == 32'd0);
   endfunction

endpackage

// File: rtl/ysyx_25040129_burst_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts, plus the
// per-beat error flag (illegal burst shape or out-of-range address).
module ysyx_25040129_burst_addr_gen
   import ysyx_25040129_pkg::*;
#(
   parameter int unsigned MEM_DIG = 10,
   parameter logic [31:0] BASE    = 32'h8000_0000
) (
   input  logic [31:0] addr_i,
   input  logic [7:0]  len_i,
   input  logic [1:0]  burst_i,
   output logic [31:0] next_addr_o,
   output logic        err_o
);

   logic [31:0] incr;
   logic [31:0] mask;
   logic        burst_ok;

   always_comb begin
      incr        = addr_i + 32'd4;
      // (len+1)*4 - 1 is the byte mask of the wrap window.
      mask        = {22'd0, len_i, 2'b11};
      burst_ok    = 1'b1;
      next_addr_o = addr_i;
      case (burst_i)
         BurstFixed: next_addr_o = addr_i;
         BurstIncr:  next_addr_o = incr;
         BurstWrap: begin
            next_addr_o = (addr_i & ~mask) | (incr & mask);
            burst_ok    = len_i inside {8'd1, 8'd3, 8'd7, 8'd15};
         end
         default: burst_ok = 1'b0;
      endcase
      err_o = !burst_ok || !addr_in_range(addr_i, BASE, MEM_DIG);
   end

endmodule

// File: rtl/ysyx_25040129_axi_burst_sram.sv
// AXI-style burst SRAM slave: single-beat writes, FIXED/INCR/WRAP read bursts
// with a programmable first-beat latency. Reads win simultaneous AR/AW.
module ysyx_25040129_axi_burst_sram
   import ysyx_25040129_pkg::*;
#(
   parameter int unsigned MEM_DIG = 10,
   parameter logic [31:0] BASE    = 32'h8000_0000,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] araddr,
   input  logic        arvalid,
   output logic        arready,
   input  logic [7:0]  arlen,
   input  logic [1:0]  arburst,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rvalid,
   input  logic        rready,
   output logic        rlast,
   input  logic [31:0] awaddr,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wvalid,
   output logic        wready,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);

   localparam int unsigned Words   = 1 << MEM_DIG;
   localparam logic [3:0]  LatInit = 4'(LATENCY - 1);

   sram_state_e state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] raddr_q, raddr_d;
   logic [7:0]  len_q, len_d;
   logic [1:0]  burst_q, burst_d;
   logic [7:0]  beat_q, beat_d;
   logic [31:0] waddr_q, waddr_d;
   logic        berr_q, berr_d;

   logic [31:0] mem_q [Words];
   logic [31:0] next_addr;
   logic        beat_err;
   logic        w_ok;
   logic        mem_we;
   logic [MEM_DIG-1:0] ridx;
   logic [MEM_DIG-1:0] widx;

   ysyx_25040129_burst_addr_gen #(
      .MEM_DIG(MEM_DIG),
      .BASE   (BASE)
   ) u_addr_gen (
      .addr_i     (raddr_q),
      .len_i      (len_q),
      .burst_i    (burst_q),
      .next_addr_o(next_addr),
      .err_o      (beat_err)
   );

   assign ridx = MEM_DIG'((raddr_q - BASE) >> 2);
   assign widx = MEM_DIG'((waddr_q - BASE) >> 2);
   assign w_ok = addr_in_range(waddr_q, BASE, MEM_DIG);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      raddr_d = raddr_q;
      len_d   = len_q;
      burst_d = burst_q;
      beat_d  = beat_q;
      waddr_d = waddr_q;
      berr_d  = berr_q;
      arready = 1'b0;
      awready = 1'b0;
      rvalid  = 1'b0;
      rlast   = 1'b0;
      rresp   = RespOkay;
      rdata   = 32'd0;
      wready  = 1'b0;
      bvalid  = 1'b0;
      bresp   = RespOkay;
      mem_we  = 1'b0;
      case (state_q)
         StIdle: begin
            arready = 1'b1;
            awready = !arvalid;
            if (arvalid) begin
               raddr_d = araddr;
               len_d   = arlen;
               burst_d = arburst;
               beat_d  = 8'd0;
               cnt_d   = LatInit;
               state_d = (LATENCY == 1) ? StRData : StRLat;
            end else if (awvalid) begin
               waddr_d = awaddr;
               state_d = StWData;
            end
         end
         StRLat: begin
            if (cnt_q == 4'd0) begin
               state_d = StRData;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StRData: begin
            rvalid = 1'b1;
            rlast  = (beat_q == len_q);
            rresp  = beat_err ? RespSlverr : RespOkay;
            rdata  = beat_err ? 32'd0 : mem_q[ridx];
            if (rready) begin
               if (rlast) begin
                  state_d = StIdle;
               end else begin
                  raddr_d = next_addr;
                  beat_d  = beat_q + 8'd1;
               end
            end
         end
         StWData: begin
            wready = 1'b1;
            if (wvalid) begin
               mem_we  = w_ok;
               berr_d  = !w_ok;
               state_d = StWResp;
            end
         end
         StWResp: begin
            bvalid = 1'b1;
            bresp  = berr_q ? RespSlverr : RespOkay;
            if (bready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         raddr_q <= 32'd0;
         len_q   <= 8'd0;
         burst_q <= BurstIncr;
         beat_q  <= 8'd0;
         waddr_q <= 32'd0;
         berr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         raddr_q <= raddr_d;
         len_q   <= len_d;
         burst_q <= burst_d;
         beat_q  <= beat_d;
         waddr_q <= waddr_d;
         berr_q  <= berr_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) begin
               mem_q[widx][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_ysyx_25040129_axi_burst_sram.sv
// Scenario bench for the burst SRAM: expected beats are queued from a bench-side
// memory model and compared as the DUT presents them.
module tb_ysyx_25040129_axi_burst_sram;

   localparam int unsigned LAT  = 2;
   localparam logic [31:0] BASE = 32'h8000_0000;

   typedef struct packed {
      logic [31:0] d;
      logic [1:0]  r;
      logic        l;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] araddr = 32'd0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [7:0]  arlen = 8'd0;
   logic [1:0]  arburst = 2'b01;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready = 1'b0;
   logic        rlast;
   logic [31:0] awaddr = 32'd0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = 32'd0;
   logic [3:0]  wstrb = 4'h0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b0;

   int checks = 0;
   int passes = 0;
   logic [31:0] mdl [1024];
   beat_t sb[$];

   ysyx_25040129_axi_burst_sram #(
      .MEM_DIG(10),
      .BASE   (BASE),
      .LATENCY(LAT)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .araddr (araddr),
      .arvalid(arvalid),
      .arready(arready),
      .arlen  (arlen),
      .arburst(arburst),
      .rdata  (rdata),
      .rresp  (rresp),
      .rvalid (rvalid),
      .rready (rready),
      .rlast  (rlast),
      .awaddr (awaddr),
      .awvalid(awvalid),
      .awready(awready),
      .wdata  (wdata),
      .wstrb  (wstrb),
      .wvalid (wvalid),
      .wready (wready),
      .bresp  (bresp),
      .bvalid (bvalid),
      .bready (bready)
   );

   always #5 clk = ~clk;

   function automatic logic mdl_ok(input logic [31:0] a);
      return (a[1:0] == 2'b00) && (a >= BASE) && (a < BASE + 32'd4096);
   endfunction

   function automatic logic [31:0] mdl_rd(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return mdl[off[11:2]];
   endfunction

   task automatic push_beat(input logic [31:0] d, input logic [1:0] r, input logic l);
      beat_t e;
      e.d = d;
      e.r = r;
      e.l = l;
      sb.push_back(e);
   endtask

   task automatic push_burst(input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst);
      logic [31:0] a, lo, wb;
      logic        legal, err;
      a = addr;
      legal = (burst == 2'b00) || (burst == 2'b01) ||
              ((burst == 2'b10) && (len == 1 || len == 3 || len == 7 || len == 15));
      for (int i = 0; i <= int'(len); i++) begin
         err = !legal || !mdl_ok(a);
         push_beat(err ? 32'd0 : mdl_rd(a), err ? 2'b10 : 2'b00, i == int'(len));
         case (burst)
            2'b01: a = a + 32'd4;
            2'b10: begin
               wb = (32'(len) + 32'd1) * 32'd4;
               lo = a - (a % wb);
               a  = lo + ((a - lo + 32'd4) % wb);
            end
            default: a = a;
         endcase
      end
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] exp_resp);
      int t;
      logic [31:0] off;
      awaddr  = addr;
      awvalid = 1'b1;
      wdata   = data;
      wstrb   = strb;
      #1;
      t = 0;
      while (!awready && t < 50) begin
         @(posedge clk);
         #1;
         t++;
      end
      checks++;
      if (awready !== 1'b1) $display("FAIL aw_wait %h: awready=%b want 1", addr, awready);
      else passes++;
      @(posedge clk);
      #1;
      awvalid = 1'b0;
      wvalid  = 1'b1;
      #1;
      checks++;
      if (wready !== 1'b1) $display("FAIL wready %h: got %b want 1", addr, wready);
      else passes++;
      @(posedge clk);
      #1;
      wvalid = 1'b0;
      checks++;
      if ({bvalid, bresp} !== {1'b1, exp_resp})
         $display("FAIL bresp %h: got v=%b r=%b want v=1 r=%b", addr, bvalid, bresp, exp_resp);
      else passes++;
      @(posedge clk);
      #1;
      checks++;
      if ({bvalid, bresp} !== {1'b1, exp_resp})
         $display("FAIL bhold %h: got v=%b r=%b want v=1 r=%b", addr, bvalid, bresp, exp_resp);
      else passes++;
      bready = 1'b1;
      @(posedge clk);
      #1;
      bready = 1'b0;
      checks++;
      if (bvalid !== 1'b0) $display("FAIL bdone %h: bvalid=%b want 0", addr, bvalid);
      else passes++;
      if (mdl_ok(addr)) begin
         off = addr - BASE;
         for (int b = 0; b < 4; b++)
            if (strb[b]) mdl[off[11:2]][8*b +: 8] = data[8*b +: 8];
      end
   endtask

   task automatic rd_burst(input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input int stall_beat, input int stall_n,
                           input bit chk_aw, input int abort_beat);
      int t, lat;
      beat_t e;
      araddr  = addr;
      arlen   = len;
      arburst = burst;
      arvalid = 1'b1;
      rready  = 1'b1;
      #1;
      t = 0;
      while (!arready && t < 50) begin
         @(posedge clk);
         #1;
         t++;
      end
      checks++;
      if (arready !== 1'b1) $display("FAIL ar_wait %h: arready=%b want 1", addr, arready);
      else passes++;
      if (chk_aw) begin
         checks++;
         if (awready !== 1'b0) $display("FAIL aw_block: awready=%b want 0", awready);
         else passes++;
      end
      @(posedge clk);
      #1;
      arvalid = 1'b0;
      lat = 0;
      while (!rvalid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checks++;
      if (lat != int'(LAT)) $display("FAIL latency %h: got %0d want %0d", addr, lat, LAT);
      else passes++;
      if (!rvalid) begin
         sb.delete();
         return;
      end
      for (int b = 0; b <= int'(len); b++) begin
         if (b == abort_beat) begin
            rst = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if ({rvalid, arready} !== 2'b01)
               $display("FAIL abort: got rvalid=%b arready=%b want 0 1", rvalid, arready);
            else passes++;
            rst = 1'b0;
            sb.delete();
            return;
         end
         checks++;
         if (sb.size() == 0) begin
            $display("FAIL sb_empty beat%0d: got 0 queued want >=1", b);
            return;
         end
         passes++;
         e = sb.pop_front();
         if (b == stall_beat) begin
            rready = 1'b0;
            repeat (stall_n) begin
               @(posedge clk);
               #1;
               checks++;
               if ({rvalid, rdata} !== {1'b1, e.d})
                  $display("FAIL stall beat%0d: got v=%b d=%h want v=1 d=%h",
                           b, rvalid, rdata, e.d);
               else passes++;
            end
            rready = 1'b1;
         end
         checks++;
         if ({rvalid, rdata, rresp, rlast} !== {1'b1, e.d, e.r, e.l})
            $display("FAIL beat%0d %h: got v=%b d=%h r=%b l=%b want v=1 d=%h r=%b l=%b",
                     b, addr, rvalid, rdata, rresp, rlast, e.d, e.r, e.l);
         else passes++;
         if (chk_aw) begin
            checks++;
            if (awready !== 1'b0) $display("FAIL aw_hold beat%0d: awready=%b want 0", b, awready);
            else passes++;
         end
         @(posedge clk);
         #1;
      end
      checks++;
      if ({rvalid, arready} !== 2'b01)
         $display("FAIL rd_end %h: got rvalid=%b arready=%b want 0 1", addr, rvalid, arready);
      else passes++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      checks++;
      if ({arready, awready, rvalid, rlast, wready, bvalid} !== 6'b110000)
         $display("FAIL reset_hs: got ar=%b aw=%b rv=%b rl=%b w=%b b=%b want 110000",
                  arready, awready, rvalid, rlast, wready, bvalid);
      else passes++;
      checks++;
      if ({rresp, bresp, rdata} !== 36'd0)
         $display("FAIL reset_data: got rresp=%b bresp=%b rdata=%h want 0 0 0",
                  rresp, bresp, rdata);
      else passes++;
   endtask

   task automatic test_write_read();
      do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00);
      push_beat(32'hDEAD_BEEF, 2'b00, 1'b1);
      rd_burst(32'h8000_0010, 8'd0, 2'b01, -1, 0, 1'b0, -1);
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 4; i++) do_write(BASE + 32'(4 * i), 32'(i), 4'hF, 2'b00);
      push_beat(32'd2, 2'b00, 1'b0);
      push_beat(32'd3, 2'b00, 1'b0);
      push_beat(32'd0, 2'b00, 1'b0);
      push_beat(32'd1, 2'b00, 1'b1);
      rd_burst(32'h8000_0008, 8'd3, 2'b10, -1, 0, 1'b0, -1);
   endtask

   task automatic test_stall();
      push_burst(BASE, 8'd3, 2'b01);
      rd_burst(BASE, 8'd3, 2'b01, 1, 3, 1'b0, -1);
   endtask

   task automatic test_ar_aw();
      awaddr  = 32'h8000_0020;
      awvalid = 1'b1;
      push_beat(32'hDEAD_BEEF, 2'b00, 1'b1);
      rd_burst(32'h8000_0010, 8'd0, 2'b01, -1, 0, 1'b1, -1);
      do_write(32'h8000_0020, 32'hCAFE_F00D, 4'hF, 2'b00);
      push_beat(32'hCAFE_F00D, 2'b00, 1'b1);
      rd_burst(32'h8000_0020, 8'd0, 2'b01, -1, 0, 1'b0, -1);
   endtask

   task automatic test_strobe();
      do_write(32'h8000_0020, 32'h1122_3344, 4'b0101, 2'b00);
      push_beat(32'hCA22_F044, 2'b00, 1'b1);
      rd_burst(32'h8000_0020, 8'd0, 2'b00, -1, 0, 1'b0, -1);
      do_write(32'h9000_0000, 32'h5555_5555, 4'hF, 2'b10);
      do_write(32'h8000_0011, 32'h6666_6666, 4'hF, 2'b10);
      push_burst(32'h8000_0010, 8'd0, 2'b01);
      rd_burst(32'h8000_0010, 8'd0, 2'b01, -1, 0, 1'b0, -1);
   endtask

   task automatic test_cross_top();
      push_beat(32'd0, 2'b10, 1'b0);
      push_beat(32'd0, 2'b00, 1'b1);
      rd_burst(32'h7FFF_FFFC, 8'd1, 2'b01, -1, 0, 1'b0, -1);
   endtask

   task automatic test_bursts();
      for (int i = 4; i < 8; i++) do_write(BASE + 32'(4 * i), 32'h40 + 32'(i), 4'hF, 2'b00);
      push_burst(32'h8000_0004, 8'd2, 2'b00);
      rd_burst(32'h8000_0004, 8'd2, 2'b00, -1, 0, 1'b0, -1);
      push_burst(32'h8000_0000, 8'd1, 2'b11);
      rd_burst(32'h8000_0000, 8'd1, 2'b11, -1, 0, 1'b0, -1);
      push_burst(32'h8000_0004, 8'd2, 2'b10);
      rd_burst(32'h8000_0004, 8'd2, 2'b10, -1, 0, 1'b0, -1);
      push_burst(32'h8000_0018, 8'd7, 2'b10);
      rd_burst(32'h8000_0018, 8'd7, 2'b10, 5, 2, 1'b0, -1);
   endtask

   task automatic test_reset_mid();
      push_burst(BASE, 8'd7, 2'b01);
      rd_burst(BASE, 8'd7, 2'b01, -1, 0, 1'b0, 2);
      push_burst(32'h8000_0004, 8'd1, 2'b01);
      rd_burst(32'h8000_0004, 8'd1, 2'b01, -1, 0, 1'b0, -1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time exceeded");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_write_read();
      test_wrap();
      test_stall();
      test_ar_aw();
      test_strobe();
      test_cross_top();
      test_bursts();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/ysyx_25040129_axi_burst_sram.md
YSYX_25040129_AXI_BURST_SRAM -- requirements
Module: ysyx_25040129_axi_burst_sram

Interface
REQ-001 SHALL have parameter MEM_DIG, default 10, meaning the memory holds 2^MEM_DIG 32-bit words.
REQ-002 SHALL have parameter BASE, default 32'h8000_0000, meaning the byte address of word 0.
REQ-003 SHALL have parameter LATENCY, default 2, meaning cycles from AR handshake to first rvalid (legal range 1..15).
REQ-004 SHALL have port clk, input, 1 bit: clock.
REQ-005 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have ports araddr (input, 32), arvalid (input, 1), arready (output, 1), arlen (input, 8, beats-1) and arburst (input, 2).
REQ-007 SHALL have ports rdata (output, 32), rresp (output, 2), rvalid (output, 1), rready (input, 1) and rlast (output, 1).
REQ-008 SHALL have ports awaddr (input, 32), awvalid (input, 1), awready (output, 1), wdata (input, 32), wstrb (input, 4), wvalid (input, 1) and wready (output, 1).
REQ-009 SHALL have ports bresp (output, 2), bvalid (output, 1) and bready (input, 1).

Function
REQ-010 SHALL implement states IDLE, R_LAT, R_DATA, W_DATA and W_RESP.
REQ-011 SHALL drive arready=1 only in IDLE, and awready=1 only in IDLE when arvalid=0, so a read wins a simultaneous AR/AW request.
REQ-012 On an AR handshake, SHALL latch araddr, arlen and arburst, load the latency counter with LATENCY-1 and enter R_LAT (R_DATA directly if LATENCY=1).
REQ-013 In R_LAT, SHALL decrement the counter each cycle and enter R_DATA at zero, so the first rvalid is asserted exactly LATENCY cycles after the AR handshake.
REQ-014 In R_DATA, SHALL assert rvalid and hold rdata/rresp/rlast stable while rready=0.
REQ-015 In R_DATA, each rvalid&&rready handshake SHALL advance to the next beat in the following cycle, with no idle cycle between beats.
REQ-016 SHALL assert rlast when the beat count equals arlen; the handshake of that beat SHALL return the block to IDLE.
REQ-017 Beat address for FIXED (2'b00) SHALL stay constant across beats.
REQ-018 Beat address for INCR (2'b01) SHALL increase by 4 per beat.
REQ-019 Beat address for WRAP (2'b10) SHALL increase by 4 and wrap within an aligned window of (arlen+1)*4 bytes.
REQ-020 WRAP with arlen not in {1,3,7,15}, and arburst=2'b11, SHALL return rresp=SLVERR with rdata=0 on every beat while still honouring arlen and rlast.
REQ-021 A beat address outside [BASE, BASE+4*2^MEM_DIG), or not word-aligned, SHALL return rresp=SLVERR with rdata=0; other beats SHALL return OKAY.
REQ-022 On an AW handshake, SHALL latch awaddr and enter W_DATA; wready=1 only in W_DATA.
REQ-023 A W handshake SHALL write the bytes enabled by wstrb (in range only) and enter W_RESP.
REQ-024 In W_RESP, SHALL assert bvalid with bresp=OKAY (in range) or SLVERR (out of range), holding both until bready, then return to IDLE.
REQ-025 Address arithmetic SHALL be 32-bit modulo 2^32; INCR bursts crossing the top of memory SHALL produce SLVERR on the out-of-range beats only.
REQ-026 A read issued right after a write to the same address SHALL return the new data.

Reset
REQ-027 On rst, SHALL enter IDLE, with arready=1, awready=1, rvalid=0, rlast=0, wready=0, bvalid=0, rresp=OKAY, bresp=OKAY and rdata=0 in the cycle after rst.
REQ-028 rst asserted mid-burst or mid-write SHALL abort the transaction with no further beats or responses.
REQ-029 Memory contents SHALL NOT be reset.

Structure
REQ-030 Response codes (OKAY=2'b00, SLVERR=2'b10) and burst codes (FIXED, INCR, WRAP) SHALL be defined in the shared ysyx_25040129 defines package, not locally.
REQ-031 Next-beat address computation (FIXED/INCR/WRAP, wrap mask, legality check) SHALL be one combinational sub-module, ysyx_25040129_burst_addr_gen.
REQ-032 Storage SHALL be a single word-wide array with byte-lane write enables.

Verification
REQ-033 Write 32'hDEADBEEF, wstrb=4'hF, to 32'h8000_0010; read arlen=0 INCR -> rvalid exactly 2 cycles after the AR handshake, rdata=32'hDEADBEEF, rresp=OKAY, rlast=1.
REQ-034 Preload words 0..3 = 0,1,2,3; read 32'h8000_0008, arlen=3, WRAP -> beats 2,3,0,1 with rlast on the 4th beat.
REQ-035 INCR, arlen=3, from 32'h8000_0000, with rready low for 3 cycles on beat 1 -> rdata held at 1 throughout the stall, 4 beats total, no gaps when rready=1.
REQ-036 arvalid and awvalid raised in the same cycle -> read served first, awready=0 until the read completes, then the write completes with bresp=OKAY.
REQ-037 Read 32'h7FFF_FFFC, arlen=1, INCR -> beat 0 SLVERR with rdata=0, beat 1 (32'h8000_0000) OKAY.
REQ-038 Assert rst during beat 2 of an arlen=7 burst -> rvalid=0 the next cycle and arready=1; a new burst then completes normally.
